td4_clock_gen: RTL

- Execution-clock stage directly upstream of TD4_top.
- Turns the board oscillator plus a mode switch and a step push-button into a single-cycle CPU clock-enable (cpu_en), in the style of the classic TD4 1 Hz / 10 Hz / manual clock circuit.
- All logic runs on the board clock; the CPU advances one instruction per cpu_en pulse.
- Also drives a tick LED and mode LEDs for the front panel.

---
 rtl/td4_clock_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/td4_clock_gen.sv
// TD4 execution clock: slow/fast free-run or debounced manual step, emitted as a one-cycle cpu_en.
// Optional hold-to-repeat in manual mode: define TD4_CLKGEN_AUTOREPEAT_EN.
module td4_clock_gen #(
  parameter int CNT_W         = 26,
  parameter int DIV_SLOW      = 50000000,
  parameter int DIV_FAST      = 5000000,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sel_manual,
  input  logic       sel_fast,
  input  logic       step_btn,
  output logic       cpu_en,
  output logic       tick_led,
  output logic [1:0] mode_led
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    SLOW   = 2'b01,
    FAST   = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] SLOW_TOP = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_TOP = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] DEB_TOP  = CNT_W'(DEB_CYCLES - 1);
  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (DIV_SLOW < 2 || DIV_FAST < 2 || DEB_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      longint'(DIV_SLOW) > CNT_LIM || longint'(DIV_FAST) > CNT_LIM ||
      longint'(DEB_CYCLES) > CNT_LIM || longint'(REPEAT_CYCLES) > CNT_LIM) begin : g_bad_params
    $error("td4_clock_gen: unsupported parameter set");
  end

  logic [1:0]       man_s_q, fast_s_q, btn_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] top;
  logic             lvl_q, lvl_d, lvl_p_q;
  logic             en_q, en_d, tick_q, tick_d;
  logic             mode_chg;
`ifdef TD4_CLKGEN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_TOP = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             act_q, act_d, rep_q, rep_d;
`endif

  always_comb begin
    state_d  = man_s_q[1] ? MANUAL : (fast_s_q[1] ? FAST : SLOW);
    mode_chg = (state_d != state_q);
    top      = (state_q == FAST) ? FAST_TOP : SLOW_TOP;

    // Debounce: any sample matching the accepted level restarts the count.
    lvl_d = lvl_q;
    deb_d = '0;
    if (btn_s_q[1] != lvl_q) begin
      if (deb_q == DEB_TOP) lvl_d = btn_s_q[1];
      else                  deb_d = deb_q + CNT_W'(1);
    end

    presc_d = '0;
    en_d    = 1'b0;
`ifdef TD4_CLKGEN_AUTOREPEAT_EN
    hold_d  = '0;
    act_d   = 1'b0;
    rep_d   = 1'b0;
`endif
    if (!mode_chg) begin
      case (state_q)
        SLOW, FAST: begin
          if (presc_q == top) en_d = 1'b1;
          else                presc_d = presc_q + CNT_W'(1);
        end
        default: begin
          if (lvl_q && !lvl_p_q) begin
            en_d = 1'b1;
`ifdef TD4_CLKGEN_AUTOREPEAT_EN
            act_d = 1'b1;
          end else if (act_q && lvl_q) begin
            // Hold phase first, then repeat at the fast rate off the idle prescaler.
            act_d = 1'b1;
            if (!rep_q) begin
              if (hold_q == REP_TOP) begin
                en_d  = 1'b1;
                rep_d = 1'b1;
              end else begin
                hold_d = hold_q + CNT_W'(1);
              end
            end else begin
              rep_d = 1'b1;
              if (presc_q == FAST_TOP) en_d = 1'b1;
              else                     presc_d = presc_q + CNT_W'(1);
            end
`endif
          end
        end
      endcase
    end
    tick_d = tick_q ^ en_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      man_s_q  <= '0;
      fast_s_q <= '0;
      btn_s_q  <= '0;
      state_q  <= MANUAL;
      presc_q  <= '0;
      deb_q    <= '0;
      lvl_q    <= 1'b0;
      lvl_p_q  <= 1'b0;
      en_q     <= 1'b0;
      tick_q   <= 1'b0;
`ifdef TD4_CLKGEN_AUTOREPEAT_EN
      hold_q   <= '0;
      act_q    <= 1'b0;
      rep_q    <= 1'b0;
`endif
    end else begin
      man_s_q  <= {man_s_q[0], sel_manual};
      fast_s_q <= {fast_s_q[0], sel_fast};
      btn_s_q  <= {btn_s_q[0], step_btn};
      state_q  <= state_d;
      presc_q  <= presc_d;
      deb_q    <= deb_d;
      lvl_q    <= lvl_d;
      lvl_p_q  <= lvl_q;
      en_q     <= en_d;
      tick_q   <= tick_d;
`ifdef TD4_CLKGEN_AUTOREPEAT_EN
      hold_q   <= hold_d;
      act_q    <= act_d;
      rep_q    <= rep_d;
`endif
    end
  end

  assign cpu_en   = en_q;
  assign tick_led = tick_q;
  assign mode_led = state_q;

endmodule
